// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge: one APB SETUP/ACCESS sequence per AHB transfer, two-cycle AHB ERROR on PSLVERR.
// Optional ACCESS timeout is enabled by defining APB_BRIDGE_TIMEOUT_EN.
module ahb_apb_bridge #(
  parameter int ADDR_WIDTH = 16,
  parameter int DEC_LSB    = 12
`ifdef APB_BRIDGE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                  i_hclk,
  input  logic                  i_hreset,
  input  logic                  i_hsel,
  input  logic [31:0]           i_haddr,
  input  logic [1:0]            i_htrans,
  input  logic                  i_hwrite,
  input  logic [31:0]           i_hwdata,
  input  logic                  i_hready,
  output logic                  o_hreadyout,
  output logic [31:0]           o_hrdata,
  output logic                  o_hresp,
  output logic [3:0]            o_dec_bits,
  output logic [ADDR_WIDTH-1:0] o_paddr,
  output logic                  o_psel,
  output logic                  o_penable,
  output logic                  o_pwrite,
  output logic [31:0]           o_pwdata,
  input  logic                  i_pready,
  input  logic [31:0]           i_prdata,
  input  logic                  i_pslverr
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_ERR1, S_ERR2} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [3:0]              r_dec_bits;
  logic                    r_pwrite;
  logic [31:0]             r_hrdata;
  logic                    w_accept;
  logic                    w_timeout;
  logic                    w_unused;

  assign w_accept = i_hsel & i_htrans[1] & i_hready &
                    ((r_state == S_IDLE) || (r_state == S_ERR2));
  assign w_unused = ^{i_htrans[0], i_haddr};

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TW-1:0] r_tmo_cnt;

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_tmo_cnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == S_ACCESS) && !i_pready) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // Fires on the wait cycle whose increment would bring the count to the limit.
  assign w_timeout = (r_state == S_ACCESS) && !i_pready &&
                     (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_state    <= S_IDLE;
      r_paddr    <= '0;
      r_dec_bits <= '0;
      r_pwrite   <= 1'b0;
      r_hrdata   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_paddr    <= i_haddr[ADDR_WIDTH-1:0];
        r_dec_bits <= i_haddr[DEC_LSB+3:DEC_LSB];
        r_pwrite   <= i_hwrite;
      end
      if ((r_state == S_ACCESS) && i_pready && !i_pslverr && !r_pwrite) begin
        r_hrdata <= i_prdata;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    o_psel      = 1'b0;
    o_penable   = 1'b0;
    o_hresp     = 1'b0;
    o_hreadyout = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_SETUP;
      end
      S_SETUP: begin
        o_psel      = 1'b1;
        o_hreadyout = 1'b0;
        w_next      = S_ACCESS;
      end
      S_ACCESS: begin
        o_psel      = 1'b1;
        o_penable   = 1'b1;
        o_hreadyout = 1'b0;
        if (i_pready) begin
          w_next = i_pslverr ? S_ERR1 : S_IDLE;
        end else if (w_timeout) begin
          w_next = S_ERR1;
        end
      end
      S_ERR1: begin
        o_hresp     = 1'b1;
        o_hreadyout = 1'b0;
        w_next      = S_ERR2;
      end
      S_ERR2: begin
        o_hresp = 1'b1;
        w_next  = w_accept ? S_SETUP : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_paddr    = r_paddr;
  assign o_dec_bits = r_dec_bits;
  assign o_pwrite   = r_pwrite;
  assign o_hrdata   = r_hrdata;
  assign o_pwdata   = i_hwdata;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Self-checking bench for ahb_apb_bridge: directed scenarios plus randomized transfers against a transaction-level model.
module tb_ahb_apb_bridge;

  logic        clk;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic [31:0] hrdata;
  logic        hresp;
  logic [3:0]  dec_bits;
  logic [15:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m_hrdata;
  logic [3:0]  m_dec;
  logic [15:0] m_paddr;
  logic        m_pwrite;

`ifdef APB_BRIDGE_TIMEOUT_EN
  ahb_apb_bridge #(.TIMEOUT_CYCLES(4)) u_dut (
    .i_hclk(clk), .i_hreset(hreset), .i_hsel(hsel), .i_haddr(haddr),
    .i_htrans(htrans), .i_hwrite(hwrite), .i_hwdata(hwdata), .i_hready(hready),
    .o_hreadyout(hreadyout), .o_hrdata(hrdata), .o_hresp(hresp),
    .o_dec_bits(dec_bits), .o_paddr(paddr), .o_psel(psel), .o_penable(penable),
    .o_pwrite(pwrite), .o_pwdata(pwdata), .i_pready(pready), .i_prdata(prdata),
    .i_pslverr(pslverr)
  );
`else
  ahb_apb_bridge u_dut (
    .i_hclk(clk), .i_hreset(hreset), .i_hsel(hsel), .i_haddr(haddr),
    .i_htrans(htrans), .i_hwrite(hwrite), .i_hwdata(hwdata), .i_hready(hready),
    .o_hreadyout(hreadyout), .o_hrdata(hrdata), .o_hresp(hresp),
    .o_dec_bits(dec_bits), .o_paddr(paddr), .o_psel(psel), .o_penable(penable),
    .o_pwrite(pwrite), .o_pwdata(pwdata), .i_pready(pready), .i_prdata(prdata),
    .i_pslverr(pslverr)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic model_reset();
    m_hrdata = '0;
    m_dec    = '0;
    m_paddr  = '0;
    m_pwrite = 1'b0;
  endtask

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rd, input int nwait, input logic err);
    hsel = 1'b1; htrans = 2'b10; hready = 1'b1; haddr = addr; hwrite = wr;
    #1;
    vectors++;
    if ({psel, penable, hreadyout} !== 3'b001) begin
      miscompares++;
      $display("FAIL addr_phase: psel/penable/hreadyout=%b want 001", {psel, penable, hreadyout});
    end
    vectors++;
    if ({paddr, dec_bits, pwrite} !== {m_paddr, m_dec, m_pwrite}) begin
      miscompares++;
      $display("FAIL addr_phase_hold: paddr/dec/pwrite=%h want %h", {paddr, dec_bits, pwrite}, {m_paddr, m_dec, m_pwrite});
    end
    @(posedge clk); #1;
    htrans = 2'b00; hsel = 1'($urandom); hwdata = wd; pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
    m_dec = addr[15:12]; m_paddr = addr[15:0]; m_pwrite = wr;
    @(negedge clk);
    vectors++;
    if ({psel, penable, hreadyout, hresp} !== 4'b1000) begin
      miscompares++;
      $display("FAIL setup: psel/penable/hreadyout/hresp=%b want 1000", {psel, penable, hreadyout, hresp});
    end
    vectors++;
    if ({paddr, dec_bits, pwrite} !== {m_paddr, m_dec, m_pwrite}) begin
      miscompares++;
      $display("FAIL setup_addr: paddr/dec/pwrite=%h want %h", {paddr, dec_bits, pwrite}, {m_paddr, m_dec, m_pwrite});
    end
    if (wr) begin
      vectors++;
      if (pwdata !== wd) begin
        miscompares++;
        $display("FAIL pwdata: got %h want %h", pwdata, wd);
      end
    end
    for (int i = 0; i <= nwait; i++) begin
      @(posedge clk); #1;
      pready  = (i == nwait);
      pslverr = err && (i == nwait);
      prdata  = (i == nwait) ? rd : $urandom;
      @(negedge clk);
      vectors++;
      if ({psel, penable, hreadyout, hresp, paddr, dec_bits, pwrite} !==
          {4'b1100, m_paddr, m_dec, m_pwrite}) begin
        miscompares++;
        $display("FAIL access: ctl/paddr/dec/pwrite=%h want %h",
                 {psel, penable, hreadyout, hresp, paddr, dec_bits, pwrite}, {4'b1100, m_paddr, m_dec, m_pwrite});
      end
    end
    @(posedge clk); #1;
    pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
    if (!err && !wr) m_hrdata = rd;
    @(negedge clk);
    if (err) begin
      vectors++;
      if ({psel, penable, hreadyout, hresp} !== 4'b0001) begin
        miscompares++;
        $display("FAIL err1: psel/penable/hreadyout/hresp=%b want 0001", {psel, penable, hreadyout, hresp});
      end
      @(posedge clk); #1;
      @(negedge clk);
      vectors++;
      if ({psel, penable, hreadyout, hresp} !== 4'b0011) begin
        miscompares++;
        $display("FAIL err2: psel/penable/hreadyout/hresp=%b want 0011", {psel, penable, hreadyout, hresp});
      end
    end else begin
      vectors++;
      if ({psel, penable, hreadyout, hresp} !== 4'b0010) begin
        miscompares++;
        $display("FAIL done: psel/penable/hreadyout/hresp=%b want 0010", {psel, penable, hreadyout, hresp});
      end
    end
    vectors++;
    if (hrdata !== m_hrdata) begin
      miscompares++;
      $display("FAIL hrdata: got %h want %h", hrdata, m_hrdata);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      case ($urandom_range(0, 2))
        0:       begin hsel = 1'b0; htrans = 2'b10; hready = 1'b1; end
        1:       begin hsel = 1'b1; htrans = 2'($urandom_range(0, 1)); hready = 1'b1; end
        default: begin hsel = 1'b1; htrans = 2'b10; hready = 1'b0; end
      endcase
      haddr = $urandom; hwrite = 1'($urandom);
      @(negedge clk);
      vectors++;
      if ({psel, penable, hreadyout, hresp, paddr, dec_bits, pwrite, hrdata} !==
          {4'b0010, m_paddr, m_dec, m_pwrite, m_hrdata}) begin
        miscompares++;
        $display("FAIL idle: ctl/paddr/dec/pwrite/hrdata=%h want %h",
                 {psel, penable, hreadyout, hresp, paddr, dec_bits, pwrite, hrdata},
                 {4'b0010, m_paddr, m_dec, m_pwrite, m_hrdata});
      end
    end
    hready = 1'b1; hsel = 1'b0; htrans = 2'b00;
  endtask

  task automatic test_reset();
    hreset = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0; hwdata = '0;
    hready = 1'b1; pready = 1'b0; prdata = '0; pslverr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({psel, penable, hreadyout, hresp, paddr, dec_bits, pwrite, hrdata} !== {4'b0010, 53'd0}) begin
      miscompares++;
      $display("FAIL reset: ctl/paddr/dec/pwrite/hrdata=%h want %h",
               {psel, penable, hreadyout, hresp, paddr, dec_bits, pwrite, hrdata}, {4'b0010, 53'd0});
    end
    hreset = 1'b0;
    idle(2);
  endtask

  task automatic test_write_basic();
    xfer(1'b1, 32'h0000_3010, 32'hDEAD_BEEF, $urandom, 0, 1'b0);
    idle(1);
  endtask

  task automatic test_read_wait();
    xfer(1'b0, 32'h0000_5004, $urandom, 32'h1234_5678, 2, 1'b0);
    idle(1);
  endtask

  task automatic test_error();
    xfer(1'b0, $urandom, $urandom, $urandom, 0, 1'b1);
    idle(2);
    xfer(1'b1, $urandom, $urandom, $urandom, 1, 1'b1);
    xfer(1'b0, $urandom, $urandom, $urandom, 0, 1'b0);
    idle(1);
  endtask

  task automatic test_back_to_back();
    xfer(1'b1, 32'h0000_0100, 32'hA5A5_0001, $urandom, 0, 1'b0);
    xfer(1'b1, 32'h0000_F200, 32'h5A5A_0002, $urandom, 0, 1'b0);
    xfer(1'b0, 32'h0000_7008, $urandom, 32'hCAFE_F00D, 1, 1'b0);
    idle(1);
  endtask

  task automatic test_reset_mid();
    hsel = 1'b1; htrans = 2'b10; hready = 1'b1; haddr = 32'h0000_9ABC; hwrite = 1'b1;
    @(posedge clk); #1;
    htrans = 2'b00; pready = 1'b0; hwdata = $urandom;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({psel, penable, hreadyout} !== 3'b110) begin
      miscompares++;
      $display("FAIL rst_pre: psel/penable/hreadyout=%b want 110", {psel, penable, hreadyout});
    end
    hreset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    vectors++;
    if ({psel, penable, hreadyout, hresp, paddr, dec_bits, hrdata} !== {4'b0010, 52'd0}) begin
      miscompares++;
      $display("FAIL rst_mid: ctl/paddr/dec/hrdata=%h want %h",
               {psel, penable, hreadyout, hresp, paddr, dec_bits, hrdata}, {4'b0010, 52'd0});
    end
    @(posedge clk); #1;
    hreset = 1'b0;
    @(negedge clk);
    xfer(1'b1, 32'h0000_4020, 32'h0BAD_F00D, $urandom, 0, 1'b0);
    idle(1);
  endtask

`ifdef APB_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    hsel = 1'b1; htrans = 2'b10; hready = 1'b1; haddr = 32'h0000_B000; hwrite = 1'b0;
    @(posedge clk); #1;
    htrans = 2'b00; pready = 1'b0; pslverr = 1'b0;
    m_dec = 4'hB; m_paddr = 16'hB000; m_pwrite = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      vectors++;
      if ({psel, penable, hreadyout, hresp} !== 4'b1100) begin
        miscompares++;
        $display("FAIL tmo_access: ctl=%b want 1100 at wait %0d", {psel, penable, hreadyout, hresp}, i);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({psel, penable, hreadyout, hresp} !== 4'b0001) begin
      miscompares++;
      $display("FAIL tmo_err1: ctl=%b want 0001", {psel, penable, hreadyout, hresp});
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({psel, penable, hreadyout, hresp} !== 4'b0011) begin
      miscompares++;
      $display("FAIL tmo_err2: ctl=%b want 0011", {psel, penable, hreadyout, hresp});
    end
    idle(1);
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      xfer(1'($urandom), $urandom, $urandom, $urandom, $urandom_range(0, 3), ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 1) != 0) idle($urandom_range(1, 3));
    end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_wait();
    test_error();
    test_back_to_back();
    test_reset_mid();
`ifdef APB_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_apb_bridge.md
# ahb_apb_bridge

AHB-Lite slave to APB master bridge that initiates APB transfers on the peripheral bus. It converts each AHB-Lite transfer into one APB SETUP/ACCESS sequence, drives the decode select bits, PSEL, PENABLE and address toward the APB slave mux, and returns PRDATA, PREADY and PSLVERR to the AHB side as HRDATA, HREADYOUT and HRESP. It sits between the AHB system interconnect and the 16-port APB slave mux.

## Interface
- ADDR_WIDTH, 16: width of PADDR, taken from HADDR[ADDR_WIDTH-1:0].
- DEC_LSB, 12: DEC_BITS = HADDR[DEC_LSB+3:DEC_LSB].
- TIMEOUT_CYCLES, 255: maximum ACCESS cycles; used only with APB_BRIDGE_TIMEOUT_EN.

Ports:
- HCLK  in  1  single clock for all logic.
- HRESET  in  1  synchronous reset, active-high.
- HSEL  in  1  bridge selected.
- HADDR  in  32  AHB address.
- HTRANS  in  2  AHB transfer type; only bit 1 is used.
- HWRITE  in  1  AHB write.
- HWDATA  in  32  AHB write data.
- HREADY  in  1  bus-level ready.
- HREADYOUT  out  1  bridge ready.
- HRDATA  out  32  read data.
- HRESP  out  1  error response.
- DEC_BITS  out  4  registered slave index, connected to the APB mux.
- PADDR  out  ADDR_WIDTH  APB address.
- PSEL  out  1  APB select, before decode.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PREADY  in  1  muxed ready.
- PRDATA  in  32  muxed read data.
- PSLVERR  in  1  muxed slave error.

## Operation
- Accept condition: HSEL & HTRANS[1] & HREADY, sampled in state IDLE or ERR2.
- On accept, register PADDR, DEC_BITS and PWRITE, then enter SETUP.
- Write data: PWDATA = HWDATA, driven combinationally. HWDATA is stable because HREADYOUT is low from SETUP until completion.
- IDLE:
  - PSEL=0, PENABLE=0.
  - On accept → SETUP.
- SETUP (one cycle):
  - PSEL=1, PENABLE=0, HREADYOUT=0.
  - → ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1, HREADYOUT=0.
  - PREADY & !PSLVERR: register HRDATA<=PRDATA (reads only; HRDATA is held otherwise), set HREADYOUT<=1, → IDLE.
  - PREADY & PSLVERR: → ERR1.
  - !PREADY: stay in ACCESS.
- ERR1:
  - PSEL=0, PENABLE=0, HRESP=1, HREADYOUT=0.
  - → ERR2.
- ERR2:
  - HRESP=1, HREADYOUT=1.
  - Accept is allowed here → SETUP; otherwise → IDLE.
- HSIZE and HPROT are not used; all APB accesses are 32-bit.
- HTRANS IDLE or BUSY while selected: no APB activity; HREADYOUT=1, HRESP=0.
- Only one APB transfer is outstanding at any time; there is no write posting.

## Timing
- Reset values:
  - State IDLE, HREADYOUT=1.
  - HRESP, PSEL and PENABLE are 0.
  - PWRITE, PADDR, DEC_BITS and HRDATA are 0.
- Reset mid-transfer: PSEL, PENABLE and HRESP are 0 and HREADYOUT is 1 from the first edge with HRESET high; the APB transfer is abandoned.
- Zero-wait APB transfer:
  - Address phase at cycle N.
  - SETUP at N+1, ACCESS at N+2 with PREADY=1.
  - HREADYOUT=1 with valid HRDATA at N+3.
  - AHB data phase is 3 cycles.
- Each APB wait state adds one cycle.
- Error transfer: ERR1 is the cycle after PREADY&PSLVERR, ERR2 the cycle after that; this is the standard two-cycle AHB ERROR response.
- Back-to-back: an accept in the completion cycle (IDLE with HREADYOUT=1) starts SETUP on the next cycle, giving no APB idle gap beyond that cycle.
- PADDR, PWRITE and DEC_BITS are held stable from SETUP through the end of ACCESS.

## Configuration
- Macro: APB_BRIDGE_TIMEOUT_EN.
- When defined:
  - An 8-bit-minimum counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES, the bridge drops PSEL/PENABLE and enters ERR1, giving HRESP=1.
  - PREADY=1 in the same cycle as the limit takes priority and completes normally.
- When undefined: ACCESS waits indefinitely, and neither the counter nor TIMEOUT_CYCLES is present.

## Test plan
- Write 0xDEADBEEF to HADDR 0x0000_3010 with PREADY=1 → PSEL and PWRITE high at N+1, PENABLE at N+2, PADDR=0x3010, DEC_BITS=3, PWDATA=0xDEADBEEF, HREADYOUT=1 at N+3, HRESP=0.
- Read HADDR 0x0000_5004 with PREADY low for 2 ACCESS cycles and PRDATA=0x12345678 → HREADYOUT low for 4 cycles, then HRDATA=0x12345678 with HREADYOUT=1.
- Read with PREADY=1 and PSLVERR=1 → HRESP=1/HREADYOUT=0, then HRESP=1/HREADYOUT=1, then HRESP=0.
- Two back-to-back writes to slaves 0 and 15 → second SETUP starts the cycle after the first completion; DEC_BITS changes 0→15 only at the second SETUP.
- APB_BRIDGE_TIMEOUT_EN with TIMEOUT_CYCLES=4 and PREADY stuck low → after 4 ACCESS cycles PSEL=0 and the two-cycle ERROR response follows.
- HRESET asserted during ACCESS → on the next edge PSEL=0, PENABLE=0, HREADYOUT=1; after release, a normal write completes in 3 cycles.
